// File: rtl/calc_pkg.sv
// ============================================================================
// Module  : calc_pkg
// Brief   : Shared types and constants for the calculator BCD conversion stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

package calc_pkg;

    localparam int BCD_W     = 4;
    localparam int NDIG      = 3;
    localparam int SHIFT_CNT = 8;
    localparam int CNT_W     = $clog2(SHIFT_CNT);

    localparam logic [BCD_W-1:0] BLANK_CODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // Only leading zeros are blanked: tens is blank only when hundreds is too.
    function automatic logic [NDIG*BCD_W-1:0] blank_leading(
        input logic [NDIG*BCD_W-1:0] digits
    );
        logic [NDIG*BCD_W-1:0] res;
        res = digits;
        if (digits[11:8] == 4'd0) begin
            res[11:8] = BLANK_CODE;
            if (digits[7:4] == 4'd0) begin
                res[7:4] = BLANK_CODE;
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/calc_bin2bcd_if.sv
// ============================================================================
// Module  : calc_bin2bcd_if
// Brief   : Valid/ready input and output bundle of the binary-to-BCD stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface calc_bin2bcd_if;
    import calc_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [7:0]       din;
    logic             out_valid;
    logic             out_ready;
    logic             neg;
    logic [BCD_W-1:0] bcd_hund;
    logic [BCD_W-1:0] bcd_tens;
    logic [BCD_W-1:0] bcd_ones;

    modport master (
        output in_valid, din, out_ready,
        input  in_ready, out_valid, neg, bcd_hund, bcd_tens, bcd_ones
    );

    modport slave (
        input  in_valid, din, out_ready,
        output in_ready, out_valid, neg, bcd_hund, bcd_tens, bcd_ones
    );

endinterface

`default_nettype wire

// File: rtl/calc_bcd_adj3.sv
// ============================================================================
// Module  : calc_bcd_adj3
// Brief   : Double-dabble digit correction: add 3 when the digit is >= 5.
// Revision: 1.0
// ============================================================================
`default_nettype none

module calc_bcd_adj3
    import calc_pkg::*;
(
    input  wire logic [BCD_W-1:0] digit_in,
    output logic      [BCD_W-1:0] digit_out
);

    assign digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;

endmodule

`default_nettype wire

// File: rtl/calc_bin2bcd.sv
// ============================================================================
// Module  : calc_bin2bcd
// Brief   : Sequential 8-bit (signed/unsigned) to sign + 3-digit BCD converter.
//           Optional macro CALC_BCD_LEADING_BLANK_EN blanks leading zeros.
// Revision: 1.0
// ============================================================================
`default_nettype none

module calc_bin2bcd
    import calc_pkg::*;
#(
    parameter bit SIGNED_IN = 1'b1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    calc_bin2bcd_if.slave   bus
);

    localparam int ACC_W = NDIG * BCD_W;

    state_t             r_state;
    logic [7:0]         r_mag;
    logic [ACC_W-1:0]   r_bcd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_neg_out;
    logic [ACC_W-1:0]   r_digits;

    logic               w_neg_in;
    logic [7:0]         w_mag_in;
    logic [ACC_W-1:0]   w_bcd_adj;
    logic [ACC_W-1:0]   w_bcd_next;
    logic [ACC_W-1:0]   w_result;

    assign w_neg_in   = SIGNED_IN && bus.din[7];
    assign w_mag_in   = w_neg_in ? 8'(~bus.din + 8'd1) : bus.din;
    assign w_bcd_next = {w_bcd_adj[ACC_W-2:0], r_mag[7]};

    for (genvar i = 0; i < NDIG; i++) begin : g_adj
        calc_bcd_adj3 u_adj (
            .digit_in  (r_bcd[i*BCD_W +: BCD_W]),
            .digit_out (w_bcd_adj[i*BCD_W +: BCD_W])
        );
    end

`ifdef CALC_BCD_LEADING_BLANK_EN
    assign w_result = blank_leading(w_bcd_next);
`else
    assign w_result = w_bcd_next;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mag       <= '0;
            r_bcd       <= '0;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_neg_out   <= 1'b0;
            r_digits    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_mag      <= w_mag_in;
                        r_neg      <= w_neg_in;
                        r_bcd      <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= CONV;
                    end
                end
                CONV: begin
                    r_bcd <= w_bcd_next;
                    r_mag <= {r_mag[6:0], 1'b0};
                    r_cnt <= r_cnt + 1'b1;
                    // Outputs are only ever touched here, so they never show a partial result.
                    if (r_cnt == CNT_W'(SHIFT_CNT - 1)) begin
                        r_neg_out   <= r_neg;
                        r_digits    <= w_result;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.neg       = r_neg_out;
    assign bus.bcd_hund  = r_digits[11:8];
    assign bus.bcd_tens  = r_digits[7:4];
    assign bus.bcd_ones  = r_digits[3:0];

endmodule

`default_nettype wire

// File: tb/tb_calc_bin2bcd.sv
// ============================================================================
// Module  : tb_calc_bin2bcd
// Brief   : Self-checking bench: signed and unsigned instances driven in lockstep.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_calc_bin2bcd;
    import calc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    calc_bin2bcd_if bs ();
    calc_bin2bcd_if bu ();

    calc_bin2bcd #(.SIGNED_IN(1'b1)) dut_s (.clk(clk), .rst(rst), .bus(bs));
    calc_bin2bcd #(.SIGNED_IN(1'b0)) dut_u (.clk(clk), .rst(rst), .bus(bu));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  din;
        logic [12:0] exp_s;
        logic [12:0] exp_u;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [12:0] disp(input logic [12:0] r);
        logic [12:0] x;
        x = r;
`ifdef CALC_BCD_LEADING_BLANK_EN
        if (x[11:8] == 4'd0) begin
            x[11:8] = 4'hF;
            if (x[7:4] == 4'd0) x[7:4] = 4'hF;
        end
`endif
        return x;
    endfunction

    // Reference: plain decimal arithmetic on the value the byte represents.
    function automatic logic [12:0] model(input logic [7:0] d, input bit sgn);
        bit n;
        int v;
        n = sgn && d[7];
        v = n ? 256 - int'(d) : int'(d);
        return disp({n, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)});
    endfunction

    function automatic logic [12:0] res_s();
        return {bs.neg, bs.bcd_hund, bs.bcd_tens, bs.bcd_ones};
    endfunction

    function automatic logic [12:0] res_u();
        return {bu.neg, bu.bcd_hund, bu.bcd_tens, bu.bcd_ones};
    endfunction

    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        bs.in_valid = v;  bu.in_valid = v;
        bs.din = d;       bu.din = d;
        bs.out_ready = r; bu.out_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic convert(input logic [7:0] d, input logic [12:0] es, input logic [12:0] eu,
                           input string tag, input int stall, input bit poke);
        int lat;
        check($sformatf("%s idle_ready", tag), 32'({bs.in_ready, bu.in_ready}), 32'b11);
        drive(1'b1, d, 1'b0);
        tick();
        lat = 0;
        while (!bs.out_valid && lat < 20) begin
            if (lat == 0)
                check($sformatf("%s busy_ready", tag), 32'({bs.in_ready, bu.in_ready}), 32'b00);
            if (poke && lat == 2) drive(1'b1, ~d, 1'b0);
            else drive(1'b0, d, 1'b0);
            tick();
            lat++;
        end
        drive(1'b0, d, 1'b0);
        check($sformatf("%s latency", tag), 32'(lat), 32'd8);
        check($sformatf("%s valid_u", tag), 32'(bu.out_valid), 32'd1);
        check($sformatf("%s res_s", tag), 32'(res_s()), 32'(es));
        check($sformatf("%s res_u", tag), 32'(res_u()), 32'(eu));
        for (int c = 0; c < stall; c++) begin
            tick();
            check($sformatf("%s stall%0d", tag, c),
                  32'({bs.out_valid, bs.in_ready, res_s(), bu.out_valid, res_u()}),
                  32'({1'b1, 1'b0, es, 1'b1, eu}));
        end
        drive(1'b0, d, 1'b1);
        tick();
        drive(1'b0, d, 1'b0);
        check($sformatf("%s release", tag),
              32'({bs.out_valid, bs.in_ready, bu.out_valid, bu.in_ready, res_s()}),
              32'({4'b0101, es}));
        if (poke) begin
            tick();
            check($sformatf("%s no_accept", tag),
                  32'({bs.in_ready, bs.out_valid}), 32'b10);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        logic [7:0] d;

        tbl[0]  = '{8'h00, {1'b0, 12'h000}, {1'b0, 12'h000}};
        tbl[1]  = '{8'h7F, {1'b0, 12'h127}, {1'b0, 12'h127}};
        tbl[2]  = '{8'h80, {1'b1, 12'h128}, {1'b0, 12'h128}};
        tbl[3]  = '{8'hF9, {1'b1, 12'h007}, {1'b0, 12'h249}};
        tbl[4]  = '{8'hFF, {1'b1, 12'h001}, {1'b0, 12'h255}};
        tbl[5]  = '{8'h81, {1'b1, 12'h127}, {1'b0, 12'h129}};
        tbl[6]  = '{8'd5,  {1'b0, 12'h005}, {1'b0, 12'h005}};
        tbl[7]  = '{8'd105,{1'b0, 12'h105}, {1'b0, 12'h105}};
        tbl[8]  = '{8'd99, {1'b0, 12'h099}, {1'b0, 12'h099}};
        tbl[9]  = '{8'd40, {1'b0, 12'h040}, {1'b0, 12'h040}};
        tbl[10] = '{8'd7,  {1'b0, 12'h007}, {1'b0, 12'h007}};

        drive(1'b0, 8'h00, 1'b0);
        #1 rst = 1'b1;
        #2;
        check("reset_state",
              32'({bs.in_ready, bs.out_valid, res_s(), bu.in_ready, bu.out_valid}),
              32'({1'b1, 1'b0, 13'h0, 1'b1, 1'b0}));
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 11; i++)
            convert(tbl[i].din, disp(tbl[i].exp_s), disp(tbl[i].exp_u),
                    $sformatf("vec%0d", i), 0, 1'b0);

        convert(8'd42, disp({1'b0, 12'h042}), disp({1'b0, 12'h042}), "backpressure", 20, 1'b1);

        // Abort a conversion of 99 after its third shift.
        drive(1'b1, 8'd99, 1'b0);
        tick();
        drive(1'b0, 8'd99, 1'b0);
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        check("rst_mid_conv",
              32'({bs.in_ready, bs.out_valid, res_s(), bu.in_ready, bu.out_valid, res_u()}),
              32'({1'b1, 1'b0, 13'h0, 1'b1, 1'b0, 13'h0}));
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bs.out_valid || bu.out_valid || !bs.in_ready) seen = 1'b1;
        end
        check("rst_no_valid", 32'(seen), 32'd0);

        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom_range(0, 255));
            convert(d, model(d, 1'b1), model(d, 1'b0), $sformatf("rand%0d_%02h", i, d),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/calc_bin2bcd.md
Name: calc_bin2bcd

Overview:
Downstream stage of the 8-bit signed divider. It takes one quotient or remainder byte at a time and converts it to sign plus three BCD digits for the calculator display.
- Sequential double-dabble: one shift per clock, 8 shift cycles per conversion.
- Valid/ready handshake on both input and output, so the display mux can pace it.

Parameters:
SIGNED_IN, 1, 1: din is two's complement and its sign is extracted. 0: din is unsigned 0..255 and neg is always 0.

Ports:
clk  input  1  single clock; all state changes on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  din is presented
in_ready  output  1  block can accept din (high only in IDLE)
din  input  8  value to convert (quotient or remainder)
out_valid  output  1  result registers hold a finished conversion
out_ready  input  1  consumer takes the result
neg  output  1  result is negative
bcd_hund  output  4  hundreds digit, 0..2
bcd_tens  output  4  tens digit, 0..9
bcd_ones  output  4  ones digit, 0..9

Behaviour:
- Reset (async, rst=1): state=IDLE, in_ready=1, out_valid=0, neg=0, all digits 4'h0, shift counter=0, working registers 0.
- States: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch mag, latch neg_r, clear the 12-bit BCD accumulator, set cnt=0, go to CONV.
  - mag = (SIGNED_IN && din[7]) ? (~din + 1) : din, taken as 8-bit unsigned. -128 (8'h80) gives mag=128.
  - neg_r = SIGNED_IN & din[7].
- CONV:
  - in_ready=0.
  - Each edge: every BCD nibble >=5 gets +3, then {bcd,mag} is shifted left 1 and cnt increments.
  - At the edge where cnt==7 (8th shift): load the output registers, set out_valid=1, go to DONE.
- Latency: out_valid is high in the 9th cycle after the accept edge. The accept edge plus 8 shift edges give the first cycle with out_valid=1.
- DONE:
  - out_valid=1; neg and digits stay stable until out_ready=1.
  - Edge with out_ready=1: out_valid=0, go to IDLE. Digits keep their last value.
  - in_ready=0 in DONE. Back-to-back throughput is 10 cycles per conversion.
- in_valid while busy is ignored; din is not sampled. The upstream must hold din and in_valid until it sees in_ready.
- Output digits and neg change only on the CONV→DONE edge. They never change mid-conversion.
- rst mid-conversion: immediate return to reset values. The partial result is discarded and out_valid is not asserted.
- Zero: neg=0 even if the input encoding is 8'h00; digits are 0,0,0.
- out_ready with out_valid=0 has no effect.

Optional Feature:
Macro CALC_BCD_LEADING_BLANK_EN.
- Defined: leading-zero digits above the ones digit are replaced by blank code 4'hF in the output registers. bcd_ones is never blanked.
  - 7 → F,F,7
  - 40 → F,4,0
  - 0 → F,F,0
- Not defined: digits are always plain BCD with leading zeros kept.
- Blanking is applied on the CONV→DONE edge; latency is unchanged.

Decomposition:
- Package calc_pkg holds:
  - state encoding type: IDLE/CONV/DONE
  - BCD_W=4, NDIG=3
  - BLANK_CODE=4'hF
  - shift count constant 8
- One sub-module, calc_bcd_adj3: combinational 4-bit add-3-if->=5 correction, instantiated 3 times inside the shift datapath.

Test Plan:
- Reset mid-CONV: din=8'd99 accepted, rst asserted on the 4th shift cycle → outputs immediately 0, in_ready=1, out_valid never pulses.
- din=8'd0 (SIGNED_IN=1) → neg=0, 0/0/0, out_valid first high 9 cycles after the accept edge.
- din=8'h7F → neg=0, 1/2/7; din=8'h80 → neg=1, 1/2/8; din=8'hF9 (-7) → neg=1, 0/0/7.
- SIGNED_IN=0, din=8'hFF → neg=0, 2/5/5.
- Backpressure: din=8'd42, out_ready held 0 for 20 cycles → out_valid and 0/4/2 stable throughout, in_ready=0. out_ready=1 → IDLE next cycle. in_valid pulsed during CONV → not accepted.
- With CALC_BCD_LEADING_BLANK_EN: din=8'd5 → F/F/5; din=8'd105 → 1/0/5; din=8'd0 → F/F/0.
